// File: rtl/gate_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Package  : gate_sweep_pkg
// Shared sweep-state encoding and standard 2-input gate truth tables.
// Revision : 1.0
// ============================================================================
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_e;

    // Bit i is the gate output for input vector i, with {a,b} = vec.
    localparam logic [3:0] TT_NAND2 = 4'b0111;
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NOR2  = 4'b0001;

endpackage
`default_nettype wire

// File: rtl/gate_sweep_sequencer_hold.sv
`default_nettype none
// ============================================================================
// Module   : sweep_hold_ctr
// Per-vector hold counter; strobes sample_o once the vector has settled.
// Revision : 1.0
// ============================================================================
module sweep_hold_ctr
    import gate_sweep_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic sample_o
);

    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign sample_o = (cnt_q == CW'(SETTLE));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            // Wrap on the sample edge so the next vector starts a fresh hold.
            cnt_d = sample_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gate_sweep_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gate_sweep_sequencer
// Sweeps all input vectors of a small gate and scores its output against EXPECT.
// Revision : 1.0
// ============================================================================
module gate_sweep_sequencer
    import gate_sweep_pkg::*;
#(
    parameter int                   N_IN   = 2,
    parameter int                   SETTLE = 1,
    parameter logic [(1<<N_IN)-1:0] EXPECT = TT_NAND2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start_i,
    output logic [N_IN-1:0]                  vec_o,
    input  logic                             gate_out_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             pass_o,
    output logic [$clog2((1<<N_IN)+1)-1:0]   err_cnt_o,
    output logic [(1<<N_IN)-1:0]             fail_map_o
);

    localparam int              NVEC     = 1 << N_IN;
    localparam int              ECW      = $clog2(NVEC + 1);
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NVEC - 1);

    sweep_state_e    state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [ECW-1:0]  err_q, err_d;
    logic [NVEC-1:0] map_q, map_d;
    logic            pass_q, pass_d;

    logic running;
    logic start_ok;
    logic sample;
    logic mismatch;

    assign running  = (state_q == RUN);
    assign start_ok = start_i && !running;
    assign mismatch = (gate_out_i != EXPECT[vec_q]);

    sweep_hold_ctr #(
        .SETTLE (SETTLE)
    ) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (start_ok),
        .en_i     (running),
        .sample_o (sample)
    );

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        err_d   = err_q;
        map_d   = map_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = RUN;
                    vec_d   = '0;
                    err_d   = '0;
                    map_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                if (sample) begin
                    if (mismatch) begin
                        err_d        = err_q + ECW'(1);
                        map_d[vec_q] = 1'b1;
                    end
                    // pass reads err_d so the final vector's result is included.
                    if (vec_q != LAST_VEC) begin
                        vec_d = vec_q + N_IN'(1);
                    end else begin
                        state_d = DONE;
                        pass_d  = (err_d == '0);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            err_q   <= '0;
            map_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            map_q   <= map_d;
            pass_q  <= pass_d;
        end
    end

    assign vec_o      = vec_q;
    assign busy_o     = running;
    assign done_o     = (state_q == DONE);
    assign pass_o     = pass_q;
    assign err_cnt_o  = err_q;
    assign fail_map_o = map_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_sweep_sequencer
// Directed and randomized sweeps of two sequencer instances against a truth-table model.
// Revision : 1.0
// ============================================================================
module tb_gate_sweep_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1;
    logic [3:0] tt0, tt1;
    logic [1:0] vec0, vec1;
    logic       g0, g1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [2:0] err0, err1;
    logic [3:0] map0, map1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural gates: output is the attached truth table indexed by the vector.
    assign g0 = tt0[vec0];
    assign g1 = tt1[vec1];

    gate_sweep_sequencer dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start0),
        .vec_o      (vec0),
        .gate_out_i (g0),
        .busy_o     (busy0),
        .done_o     (done0),
        .pass_o     (pass0),
        .err_cnt_o  (err0),
        .fail_map_o (map0)
    );

    gate_sweep_sequencer #(
        .N_IN   (2),
        .SETTLE (0),
        .EXPECT (4'b0110)
    ) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start1),
        .vec_o      (vec1),
        .gate_out_i (g1),
        .busy_o     (busy1),
        .done_o     (done1),
        .pass_o     (pass1),
        .err_cnt_o  (err1),
        .fail_map_o (map1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start0 = v;
        else          start1 = v;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input int sel, input string tag, input int e_vec, input bit e_busy,
                             input bit e_done, input bit e_pass, input int e_err, input logic [3:0] e_map);
        chk({tag, ".vec"},  (sel == 0) ? 32'(vec0)  : 32'(vec1),  32'(e_vec));
        chk({tag, ".busy"}, (sel == 0) ? 32'(busy0) : 32'(busy1), 32'(e_busy));
        chk({tag, ".done"}, (sel == 0) ? 32'(done0) : 32'(done1), 32'(e_done));
        chk({tag, ".pass"}, (sel == 0) ? 32'(pass0) : 32'(pass1), 32'(e_pass));
        chk({tag, ".err"},  (sel == 0) ? 32'(err0)  : 32'(err1),  32'(e_err));
        chk({tag, ".map"},  (sel == 0) ? 32'(map0)  : 32'(map1),  32'(e_map));
    endtask

    // One sweep with gate truth table tt. restart_edge: edge at which start is
    // re-asserted mid-run (-1 none); abort_edge: edge after which reset hits (-1 none).
    task automatic run_sweep(input int sel, input logic [3:0] tt, input int restart_edge,
                             input int abort_edge, input string tag);
        int         hold;
        int         len;
        int         n;
        logic [3:0] ex;
        logic [3:0] full;
        logic [3:0] m;
        hold = (sel == 0) ? 2 : 1;
        len  = 4 * hold;
        ex   = (sel == 0) ? 4'b0111 : 4'b0110;
        full = tt ^ ex;
        if (sel == 0) tt0 = tt;
        else          tt1 = tt;
        set_start(sel, 1'b1);
        tick();
        set_start(sel, 1'b0);
        for (int k = 0; k <= len; k++) begin
            n = k / hold;
            m = full & 4'((1 << n) - 1);
            if (k < len)
                check_all(sel, tag, k / hold, 1'b1, 1'b0, 1'b0, $countones(m), m);
            else
                check_all(sel, tag, 3, 1'b0, 1'b1, full == 4'b0000, $countones(full), full);
            if (k == abort_edge) begin
                #3 rst_n = 1'b0;
                #1 check_all(sel, {tag, ".abort"}, 0, 1'b0, 1'b0, 1'b0, 0, 4'b0000);
                #7 rst_n = 1'b1;
                tick();
                check_all(sel, {tag, ".post_rst"}, 0, 1'b0, 1'b0, 1'b0, 0, 4'b0000);
                return;
            end
            if (k < len) begin
                if (k + 1 == restart_edge) set_start(sel, 1'b1);
                tick();
                set_start(sel, 1'b0);
            end
        end
        repeat (2) tick();
        check_all(sel, {tag, ".hold"}, 3, 1'b0, 1'b1, full == 4'b0000, $countones(full), full);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int sel;
        int len;
        int rs;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        tt0    = 4'b0111;
        tt1    = 4'b0110;
        #2;
        check_all(0, "reset0", 0, 1'b0, 1'b0, 1'b0, 0, 4'b0000);
        check_all(1, "reset1", 0, 1'b0, 1'b0, 1'b0, 0, 4'b0000);
        #10 rst_n = 1'b1;

        run_sweep(0, 4'b0111, -1, -1, "nand_ok");
        run_sweep(0, 4'b1111, -1, -1, "tied1");
        run_sweep(0, 4'b1000, -1, -1, "and_gate");
        run_sweep(1, 4'b0110, -1, -1, "xor_s0");
        run_sweep(1, 4'b0110, -1, -1, "xor_again");
        run_sweep(1, 4'b1001, -1, -1, "xnor_on_xor");
        run_sweep(1, 4'b0110, -1, -1, "xor_clear");
        run_sweep(0, 4'b0111,  3, -1, "restart_run");
        run_sweep(0, 4'b0111,  2,  5, "abort");
        run_sweep(0, 4'b0111, -1, -1, "after_abort");

        for (int i = 0; i < 12; i++) begin
            sel = int'($urandom_range(0, 1));
            len = (sel == 0) ? 8 : 4;
            rs  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, len - 1)) : -1;
            run_sweep(sel, 4'($urandom_range(0, 15)), rs, -1, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gate_sweep_sequencer.md
Name: gate_sweep_sequencer

Overview:
- Self-contained sequential stimulus and check stage for the course's small combinational gates (NAND and its siblings).
- Sits directly upstream of the gate under test and also consumes the gate's output.
- Exhaustively sweeps all 2^N_IN input vectors, holds each for a programmable settle time, samples the gate output and compares it to a parameterised truth table.
- Reports pass/fail, a mismatch count and a per-vector failure map, so gates can be exercised in synthesisable logic rather than by a procedural loop.

Parameters:
- N_IN, 2, number of gate inputs; vectors 0 .. 2^N_IN-1.
- SETTLE, 1, extra hold cycles per vector before sampling (0 allowed); each vector is held SETTLE+1 cycles.
- EXPECT, 4'b0111, expected truth table, width 2^N_IN; bit i is the expected gate_out for vec==i. The default is NAND with {a,b}=vec.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep; honoured only in IDLE or DONE.
- vec  output  N_IN  stimulus to the gate. With N_IN=2, {a,b}=vec; vec[N_IN-1] is the MSB and maps to a.
- gate_out  input  1  gate response; combinational from vec.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start or reset.
- pass  output  1  valid while done: 1 if err_cnt==0.
- err_cnt  output  $clog2(2^N_IN+1)  number of mismatching vectors in the last or current sweep.
- fail_map  output  2^N_IN  bit i is set if vector i mismatched.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; vec=0, busy=0, done=0, pass=0, err_cnt=0, fail_map=0, internal hold counter=0.
- Reset asserted mid-sweep aborts immediately to these values. No partial results are retained.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge → RUN with vec=0, hold cnt=0, busy=1, err_cnt=0, fail_map=0.
  - start=0 → stay in IDLE.
- RUN:
  - Each edge with cnt<SETTLE: cnt++ and vec is unchanged.
  - Edge with cnt==SETTLE (the sample edge): compare gate_out to EXPECT[vec].
  - On mismatch: err_cnt++ and fail_map[vec]=1.
  - If vec != 2^N_IN-1: vec++ and cnt=0.
  - Otherwise: → DONE with busy=0, done=1 and pass=(final err_cnt==0). The last comparison is included in pass.
- DONE:
  - Outputs are held; vec stays at 2^N_IN-1.
  - start=1 → identical to start from IDLE: clears results, done=0, busy=1, vec=0.
- start while in RUN is ignored and has no effect on the sweep.
- Timing:
  - The start edge is cycle 0.
  - Vector i is driven from edge i*(SETTLE+1) and sampled at edge (i+1)*(SETTLE+1).
  - done rises at edge 2^N_IN*(SETTLE+1); with the defaults this is edge 8.
- Widths:
  - err_cnt saturation is unreachable; its maximum is 2^N_IN.
  - The hold counter is $clog2(SETTLE+1) bits, minimum 1.
  - vec wrap never occurs; the terminal vector transitions to DONE.
- gate_out is sampled only on sample edges; its value at all other edges is don't-care.
- pass is 0 whenever done=0.

Decomposition:
- Package gate_sweep_pkg holds:
  - state enum sweep_state_e {IDLE, RUN, DONE};
  - truth-table constants TT_NAND2=4'b0111, TT_AND2=4'b1000, TT_OR2=4'b1110, TT_XOR2=4'b0110, TT_NOR2=4'b0001.
- One sub-module: sweep_hold_ctr.
  - Parameterised by SETTLE.
  - Inputs: clr and en.
  - Output: a one-bit sample strobe asserted when cnt==SETTLE.
- The FSM, vector counter and scoreboard live in the top module.

Test Plan:
- Correct gate, default parameters, behavioural NAND on vec, pulse start at cycle 0:
  - vec steps 0,1,2,3 every 2 cycles;
  - done=1 at edge 8, pass=1, err_cnt=0, fail_map=4'b0000.
- gate_out tied to 1, EXPECT=TT_NAND2: done at edge 8, pass=0, err_cnt=1, fail_map=4'b1000.
- AND gate attached, EXPECT=TT_NAND2: err_cnt=4, fail_map=4'b1111, pass=0.
- SETTLE=0, XOR gate, EXPECT=TT_XOR2:
  - vec changes every cycle;
  - done at edge 4, pass=1.
  - Then pulse start again while in DONE: done drops next edge, err_cnt/fail_map clear, and the sweep repeats with pass=1.
- Start re-pulsed at edge 3 during RUN: ignored; done still at edge 8 with an unchanged vec sequence.
- Start re-pulsed during RUN, then rst_n asserted low asynchronously at edge 5 (mid-clock): all outputs zero immediately. Release reset, then start: a full clean sweep completes, pass=1.
